// File: rtl/mlu_mul_seq.sv
// -----------------------------------------------------------------------------
// common: shared MLU opcode encodings. Only the two opcodes that the multiplier
// drives are listed here.
//
// mlu_mul_seq: iterative 32x32 -> 64-bit unsigned shift-and-add multiplier.
// It borrows the neighbouring MLU adder for one step per clock while in RUN,
// and parks the MLU on NOP0 at every other time.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake; REQ_A multiplicand, REQ_B multiplier
//   RES_VALID/READY     result handshake; RES_HI:RES_LO product,
//                       RES_Z product==0, RES_OVF upper half non-zero
//   MLU_A/B/OP/C_IN     operands driven to the MLU
//   MLU_OUT, MLU_C      MLU sum and carry-out (combinational return path)
//
// state | meaning
// IDLE  | ready for a request, MLU parked on NOP0
// RUN   | 32 shift-and-add steps, MLU performs acc_hi + (lo bit ? mcand : 0)
// DONE  | product held on RES_* until RES_READY
// -----------------------------------------------------------------------------
package common;
  localparam logic [2:0] MLU_NOP0 = 3'b000;
  localparam logic [2:0] MLU_ADD  = 3'b001;
endpackage

module mlu_mul_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] REQ_A,
  input  logic [31:0] REQ_B,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_LO,
  output logic [31:0] RES_HI,
  output logic        RES_Z,
  output logic        RES_OVF,
  output logic [31:0] MLU_A,
  output logic [31:0] MLU_B,
  output logic [2:0]  MLU_OP,
  output logic        MLU_C_IN,
  input  logic [31:0] MLU_OUT,
  input  logic        MLU_C
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            mcand  <= REQ_A;
            acc_lo <= REQ_B;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          // The 33-bit partial sum shifts right by one; its LSB enters the
          // top of acc_lo as the multiplier bit just consumed leaves the bottom.
          acc_hi <= {MLU_C, MLU_OUT[31:1]};
          acc_lo <= {MLU_OUT[0], acc_lo[31:1]};
          cnt    <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RES_VALID = 1'b0;
    MLU_OP    = common::MLU_NOP0;
    MLU_A     = '0;
    MLU_B     = '0;
    MLU_C_IN  = 1'b0;
    case (state)
      S_IDLE: begin
        REQ_READY = !RST;
        if (REQ_VALID) state_nxt = S_RUN;
      end
      S_RUN: begin
        MLU_OP = common::MLU_ADD;
        MLU_A  = acc_hi;
        MLU_B  = acc_lo[0] ? mcand : 32'd0;
        if (cnt == 5'd31) state_nxt = S_DONE;
      end
      S_DONE: begin
        RES_VALID = 1'b1;
        if (RES_READY) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result fields come straight off the accumulator; the accumulator is
  // frozen outside RUN, so they stay stable under backpressure.
  assign RES_HI  = acc_hi;
  assign RES_LO  = acc_lo;
  assign RES_Z   = ({acc_hi, acc_lo} == 64'd0);
  assign RES_OVF = (acc_hi != 32'd0);

`ifdef FORMAL
  logic [63:0] f_prod;

  always_ff @(posedge CLK) begin
    if (RST) begin
      f_prod <= '0;
    end else if (state == S_IDLE && REQ_VALID) begin
      f_prod <= {32'd0, REQ_A} * {32'd0, REQ_B};
    end
  end

  always_comb begin
    if (RES_VALID) assert ({RES_HI, RES_LO} == f_prod);
    if (MLU_OP == common::MLU_ADD) assert (MLU_C_IN == 1'b0);
  end
`endif

endmodule

// File: tb/tb_mlu_mul_seq.sv
module tb_mlu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        res_z;
  logic        res_ovf;
  logic [31:0] mlu_a;
  logic [31:0] mlu_b;
  logic [2:0]  mlu_op;
  logic        mlu_c_in;
  logic [31:0] mlu_out;
  logic        mlu_c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  always #5 clk = ~clk;

  mlu_mul_seq dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_A(req_a), .REQ_B(req_b),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_LO(res_lo), .RES_HI(res_hi),
    .RES_Z(res_z), .RES_OVF(res_ovf),
    .MLU_A(mlu_a), .MLU_B(mlu_b), .MLU_OP(mlu_op), .MLU_C_IN(mlu_c_in),
    .MLU_OUT(mlu_out), .MLU_C(mlu_c)
  );

  // Behavioural MLU: ADD returns sum and carry, NOP0 returns zero.
  assign {mlu_c, mlu_out} = (mlu_op == common::MLU_ADD)
                          ? ({1'b0, mlu_a} + {1'b0, mlu_b} + {32'd0, mlu_c_in})
                          : 33'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push the reference product on accept, pop on result handshake.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        chk("sb_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_product", {res_hi, res_lo}, mon_e);
          chk("sb_z", res_z, mon_e == 64'd0);
          chk("sb_ovf", res_ovf, mon_e[63:32] != 32'd0);
        end
      end
      if (req_valid && req_ready) exp_q.push_back({32'd0, req_a} * {32'd0, req_b});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    chk("wait_req_ready", req_ready, 1'b1);
  endtask

  // Accept one request, then count RUN cycles until RES_VALID.
  task automatic issue_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input bit check_b0);
    int n = 0;
    bit bad_op = 0;
    bit bad_b = 0;
    wait_ready();
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    while (!res_valid && n < 40) begin
      if (mlu_op !== common::MLU_ADD || mlu_c_in !== 1'b0) bad_op = 1;
      if (mlu_b !== 32'd0) bad_b = 1;
      step();
      n++;
    end
    chk("latency", n, 32);
    chk("run_mlu_add", bad_op, 1'b0);
    if (check_b0) chk("run_mlu_b_zero", bad_b, 1'b0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic e_z, input logic e_ovf, input bit check_b0);
    issue_and_wait(a, b, check_b0);
    chk("done_hi", res_hi, e_hi);
    chk("done_lo", res_lo, e_lo);
    chk("done_z", res_z, e_z);
    chk("done_ovf", res_ovf, e_ovf);
    chk("done_req_ready", req_ready, 1'b0);
    chk("done_mlu_nop", mlu_op, common::MLU_NOP0);
    step();
    chk("after_done_idle", req_ready, 1'b1);
  endtask

  initial begin
    int n;
    int prev_acc;
    int acc_cyc;
    bit seen;

    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready, 1'b1);
    chk("post_rst_res_hi", res_hi, 32'd0);
    chk("post_rst_res_lo", res_lo, 32'd0);
    chk("post_rst_res_z", res_z, 1'b1);
    chk("post_rst_res_ovf", res_ovf, 1'b0);
    chk("post_rst_mlu_op", mlu_op, common::MLU_NOP0);
    chk("post_rst_mlu_a", mlu_a, 32'd0);
    chk("post_rst_mlu_b", mlu_b, 32'd0);
    chk("post_rst_mlu_c_in", mlu_c_in, 1'b0);

    run_op(32'd3, 32'd5, 32'd0, 32'h0000000F, 1'b0, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1, 1'b0);
    run_op(32'd0, 32'h12345678, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Backpressure with a second request held during DONE.
    res_ready = 1'b0;
    issue_and_wait(32'h00010000, 32'h00010000, 1'b0);
    req_a = 32'd3;
    req_b = 32'd4;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_hi", res_hi, 32'h00000001);
      chk("bp_res_lo", res_lo, 32'd0);
      chk("bp_req_ready", req_ready, 1'b0);
      step();
    end
    res_ready = 1'b1;
    step();
    chk("bp_idle_req_ready", req_ready, 1'b1);
    chk("bp_idle_res_valid", res_valid, 1'b0);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_second_latency", n, 32);
    chk("bp_second_lo", res_lo, 32'd12);
    step();

    // Reset in the middle of RUN.
    wait_ready();
    req_a = 32'd7;
    req_b = 32'd9;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (17) step();
    rst = 1'b1;
    step();
    chk("midrst_mlu_op", mlu_op, common::MLU_NOP0);
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_idle", req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) seen = 1;
      step();
    end
    chk("midrst_no_result", seen, 1'b0);
    run_op(32'd7, 32'd9, 32'd0, 32'h0000003F, 1'b0, 1'b0, 1'b0);

    // Back-to-back random operations with REQ_VALID held high.
    res_ready = 1'b1;
    prev_acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      req_a = $urandom;
      req_b = $urandom;
      if (i == 1) req_a = 32'd0;
      if (i == 2) begin
        req_a = 32'hFFFFFFFF;
        req_b = 32'hFFFFFFFF;
      end
      wait_ready();
      acc_cyc = cyc;
      step();
      if (i > 0) chk("b2b_interval", acc_cyc - prev_acc, 34);
      prev_acc = acc_cyc;
    end
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
